// File: rtl/receiver_burst_sequencer.sv
// ---------------------------------------------------------------------------
// receiver_burst_sequencer
//   Packs the receiver ADC sample stream into bursts of fixed-length packets.
//   An enabled block arms with a latched burst length, then captures one
//   packet of N_SAMPLES valid samples per trigger rising edge until the
//   burst completes or enable is withdrawn at a packet boundary.
//
//   Optional build macro: RX_SEQ_OFFSET_BINARY_EN
//     defined   -> opData is offset binary (sign bit inverted)
//     undefined -> opData is the two's complement input sample unchanged
//
// Ports
//   ipClk, ipnReset         clock, asynchronous active-low reset
//   ipEnable                level enable; arms bursts, stops at packet end
//   ipBurstLength[INDEX_W]  packets per burst, latched on arming (0 = never)
//   ipTrigger               pulse trigger, rising edge sensitive
//   ipClearStatus           clears opOverrun / opMissedCount
//   ipSampleData[14]        ADC sample, two's complement
//   ipSampleValid           sample strobe
//   opData, opValid         registered output sample and strobe
//   opSoP/opEoP/opSoB/opEoB packet / burst boundary flags (qualified by opValid)
//   opPacketIndex[INDEX_W]  current or next packet index within the burst
//   opBusy                  state is not Idle
//   opBurstDone             one-cycle pulse with the last sample of a burst
//   opOverrun               sticky: trigger edge arrived while sampling
//   opMissedCount[8]        saturating count of triggers seen while sampling
// ---------------------------------------------------------------------------
module receiver_burst_sequencer #(
  parameter int unsigned N_SAMPLES = 2500,
  parameter int unsigned INDEX_W   = 8
) (
  input  logic               ipClk,
  input  logic               ipnReset,
  input  logic               ipEnable,
  input  logic [INDEX_W-1:0] ipBurstLength,
  input  logic               ipTrigger,
  input  logic               ipClearStatus,
  input  logic [13:0]        ipSampleData,
  input  logic               ipSampleValid,
  output logic               opSoP,
  output logic               opEoP,
  output logic               opSoB,
  output logic               opEoB,
  output logic [13:0]        opData,
  output logic               opValid,
  output logic [INDEX_W-1:0] opPacketIndex,
  output logic               opBusy,
  output logic               opBurstDone,
  output logic               opOverrun,
  output logic [7:0]         opMissedCount
);

  localparam int unsigned DATA_W = 14;
  localparam int unsigned MISS_W = 8;
  // Sample counter only has to reach N_SAMPLES-1; keep at least one bit.
  localparam int unsigned CNT_W  = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] LAST_N = CNT_W'(N_SAMPLES - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_SAMPLING = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               trig_prev_q;
  logic [INDEX_W-1:0] len_q, len_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;
  logic               sob_q, sob_d;
  logic               eob_q, eob_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               ovr_q, ovr_d;
  logic [MISS_W-1:0]  missed_q, missed_d;

  logic               trig_edge;
  logic               pkt_first;
  logic               pkt_last;
  logic               burst_first;
  logic               burst_last;
  logic [DATA_W-1:0]  sample_fmt;

  assign trig_edge   = ipTrigger & ~trig_prev_q;
  assign pkt_first   = (n_q == '0);
  assign pkt_last    = (n_q == LAST_N);
  assign burst_first = (idx_q == '0);
  assign burst_last  = (idx_q == (len_q - INDEX_W'(1)));

  // Output sample format selection.
`ifdef RX_SEQ_OFFSET_BINARY_EN
  assign sample_fmt = {~ipSampleData[DATA_W-1], ipSampleData[DATA_W-2:0]};
`else
  assign sample_fmt = ipSampleData;
`endif

  // Next-state, status and output flag logic.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    n_d      = n_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    sob_d    = 1'b0;
    eob_d    = 1'b0;
    done_d   = 1'b0;
    ovr_d    = ovr_q;
    missed_d = missed_q;

    // Clear first so a coincident overrun still registers as one event.
    if (ipClearStatus) begin
      ovr_d    = 1'b0;
      missed_d = '0;
    end
    if (trig_edge && (state_q == ST_SAMPLING)) begin
      ovr_d = 1'b1;
      if (missed_d != '1) begin
        missed_d = missed_d + MISS_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (ipEnable && (ipBurstLength != '0)) begin
          state_d = ST_ARMED;
          len_d   = ipBurstLength;
          idx_d   = '0;
        end
      end
      ST_ARMED: begin
        if (!ipEnable) begin
          state_d = ST_IDLE;
        end else if (trig_edge) begin
          state_d = ST_SAMPLING;
          n_d     = '0;
        end
      end
      ST_SAMPLING: begin
        if (ipSampleValid) begin
          valid_d = 1'b1;
          data_d  = sample_fmt;
          sop_d   = pkt_first;
          eop_d   = pkt_last;
          sob_d   = pkt_first & burst_first;
          eob_d   = pkt_last & burst_last;
          if (pkt_last) begin
            // Packet always completes; enable is only honoured here.
            if (burst_last) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else if (!ipEnable) begin
              state_d = ST_IDLE;
            end else begin
              idx_d   = idx_q + INDEX_W'(1);
              state_d = ST_ARMED;
            end
          end else begin
            n_d = n_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      state_q     <= ST_IDLE;
      trig_prev_q <= 1'b0;
      len_q       <= '0;
      idx_q       <= '0;
      n_q         <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      sob_q       <= 1'b0;
      eob_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
      missed_q    <= '0;
    end else begin
      state_q     <= state_d;
      trig_prev_q <= ipTrigger;
      len_q       <= len_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      sob_q       <= sob_d;
      eob_q       <= eob_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
      missed_q    <= missed_d;
    end
  end

  assign opSoP         = sop_q;
  assign opEoP         = eop_q;
  assign opSoB         = sob_q;
  assign opEoB         = eob_q;
  assign opData        = data_q;
  assign opValid       = valid_q;
  assign opPacketIndex = idx_q;
  assign opBusy        = busy_q;
  assign opBurstDone   = done_q;
  assign opOverrun     = ovr_q;
  assign opMissedCount = missed_q;

endmodule

// File: tb/tb_receiver_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_receiver_burst_sequencer
//   Directed burst scenarios followed by random stimulus, all compared every
//   cycle against a behavioural model of the burst sequencing rules.
// ---------------------------------------------------------------------------
module tb_receiver_burst_sequencer;

  localparam int unsigned NS = 4;
  localparam int unsigned IW = 8;

  logic          ipClk = 1'b0;
  logic          ipnReset;
  logic          ipEnable;
  logic [IW-1:0] ipBurstLength;
  logic          ipTrigger;
  logic          ipClearStatus;
  logic [13:0]   ipSampleData;
  logic          ipSampleValid;
  logic          opSoP, opEoP, opSoB, opEoB;
  logic [13:0]   opData;
  logic          opValid;
  logic [IW-1:0] opPacketIndex;
  logic          opBusy;
  logic          opBurstDone;
  logic          opOverrun;
  logic [7:0]    opMissedCount;

  receiver_burst_sequencer #(.N_SAMPLES(NS), .INDEX_W(IW)) dut (
    .ipClk         (ipClk),
    .ipnReset      (ipnReset),
    .ipEnable      (ipEnable),
    .ipBurstLength (ipBurstLength),
    .ipTrigger     (ipTrigger),
    .ipClearStatus (ipClearStatus),
    .ipSampleData  (ipSampleData),
    .ipSampleValid (ipSampleValid),
    .opSoP         (opSoP),
    .opEoP         (opEoP),
    .opSoB         (opSoB),
    .opEoB         (opEoB),
    .opData        (opData),
    .opValid       (opValid),
    .opPacketIndex (opPacketIndex),
    .opBusy        (opBusy),
    .opBurstDone   (opBurstDone),
    .opOverrun     (opOverrun),
    .opMissedCount (opMissedCount)
  );

  always #5 ipClk = ~ipClk;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: a burst is "active" while armed or capturing.
  bit          m_active, m_capt, m_prev_trig, m_ovr;
  int          m_len, m_idx, m_n, m_missed;
  bit          e_valid, e_sop, e_eop, e_sob, e_eob, e_done;
  logic [13:0] e_data;

  // Per-scenario observation of DUT output samples.
  int          s_cnt;
  logic [31:0] sop_mask, eop_mask, sob_mask, eob_mask, done_mask;
  bit          busy_at_done;
  logic [13:0] data_log [0:31];

  function automatic logic [13:0] expect_data(input logic [13:0] d);
`ifdef RX_SEQ_OFFSET_BINARY_EN
    return d + 14'h2000;
`else
    return d;
`endif
  endfunction

  task automatic model_reset();
    m_active = 0; m_capt = 0; m_prev_trig = 0; m_ovr = 0;
    m_len = 0; m_idx = 0; m_n = 0; m_missed = 0;
  endtask

  task automatic model_step();
    bit edge_seen;
    edge_seen   = ipTrigger && !m_prev_trig;
    m_prev_trig = ipTrigger;
    e_valid = 0; e_sop = 0; e_eop = 0; e_sob = 0; e_eob = 0; e_done = 0;
    if (ipClearStatus) begin
      m_ovr = 0; m_missed = 0;
    end
    if (edge_seen && m_capt) begin
      m_ovr = 1;
      if (m_missed < 255) m_missed++;
    end
    if (!m_active) begin
      if (ipEnable && ipBurstLength != 0) begin
        m_active = 1; m_len = int'(ipBurstLength); m_idx = 0;
      end
    end else if (!m_capt) begin
      if (!ipEnable) m_active = 0;
      else if (edge_seen) begin m_capt = 1; m_n = 0; end
    end else if (ipSampleValid) begin
      e_valid = 1;
      e_data  = expect_data(ipSampleData);
      e_sop   = (m_n == 0);
      e_eop   = (m_n == NS - 1);
      e_sob   = e_sop && (m_idx == 0);
      e_eob   = e_eop && (m_idx == m_len - 1);
      if (m_n == NS - 1) begin
        m_capt = 0;
        if (m_idx == m_len - 1) begin m_active = 0; e_done = 1; end
        else if (!ipEnable) m_active = 0;
        else m_idx++;
      end else begin
        m_n++;
      end
    end
  endtask

  task automatic clear_obs();
    s_cnt = 0; sop_mask = 0; eop_mask = 0; sob_mask = 0; eob_mask = 0;
    done_mask = 0; busy_at_done = 1;
  endtask

  // One clock: predict, advance, then compare just after the edge.
  task automatic tick();
    model_step();
    @(posedge ipClk);
    #1;
    check_val("valid", 32'(opValid), 32'(e_valid));
    check_val("sop",   32'(opSoP),   32'(e_sop));
    check_val("eop",   32'(opEoP),   32'(e_eop));
    check_val("sob",   32'(opSoB),   32'(e_sob));
    check_val("eob",   32'(opEoB),   32'(e_eob));
    check_val("done",  32'(opBurstDone), 32'(e_done));
    check_val("busy",  32'(opBusy),  32'(m_active));
    check_val("index", 32'(opPacketIndex), 32'(m_idx));
    check_val("overrun", 32'(opOverrun), 32'(m_ovr));
    check_val("missed", 32'(opMissedCount), 32'(m_missed));
    if (e_valid) check_val("data", 32'(opData), 32'(e_data));
    if (opBurstDone) busy_at_done = opBusy;
    if (opValid && s_cnt < 32) begin
      if (opSoP) sop_mask |= 32'(1) << s_cnt;
      if (opEoP) eop_mask |= 32'(1) << s_cnt;
      if (opSoB) sob_mask |= 32'(1) << s_cnt;
      if (opEoB) eob_mask |= 32'(1) << s_cnt;
      if (opBurstDone) done_mask |= 32'(1) << s_cnt;
      data_log[s_cnt] = opData;
      s_cnt++;
    end
  endtask

  task automatic idle_inputs();
    ipEnable = 0; ipBurstLength = 0; ipTrigger = 0; ipClearStatus = 0;
    ipSampleValid = 0; ipSampleData = 0;
  endtask

  initial begin
    logic [7:0] trig_seq, valid_seq;
    int ntrig;
    logic [13:0] exp0, exp1;

    idle_inputs();
    ipnReset = 0;
    model_reset();
    clear_obs();
    repeat (2) @(posedge ipClk);
    #1;
    check_val("rst_valid", 32'(opValid), 0);
    check_val("rst_busy", 32'(opBusy), 0);
    check_val("rst_index", 32'(opPacketIndex), 0);
    check_val("rst_missed", 32'(opMissedCount), 0);
    ipnReset = 1;

    // Burst of three packets with continuous valid strobes.
    clear_obs();
    ipEnable = 1; ipBurstLength = 3; ipSampleValid = 1; ntrig = 0;
    for (int c = 0; c < 20; c++) begin
      ipSampleData = 14'($urandom);
      if (m_active && !m_capt && !ipTrigger && ntrig < 3) begin
        ipTrigger = 1; ntrig++;
      end else ipTrigger = 0;
      tick();
    end
    check_val("b3_count", 32'(s_cnt), 12);
    check_val("b3_sop_pos", sop_mask, 32'h111);
    check_val("b3_eop_pos", eop_mask, 32'h888);
    check_val("b3_sob_pos", sob_mask, 32'h001);
    check_val("b3_eob_pos", eob_mask, 32'h800);
    check_val("b3_done_pos", done_mask, 32'h800);
    check_val("b3_busy_at_done", 32'(busy_at_done), 0);
    idle_inputs();
    repeat (3) tick();

    // Two trigger edges mid-packet, then a status clear.
    clear_obs();
    trig_seq  = 8'b0010_1010;
    valid_seq = 8'b0111_0100;
    ipEnable = 1; ipBurstLength = 1;
    for (int c = 0; c < 8; c++) begin
      ipTrigger = trig_seq[c];
      ipSampleValid = valid_seq[c];
      ipSampleData = 14'($urandom);
      tick();
    end
    check_val("ovr_set", 32'(opOverrun), 1);
    check_val("ovr_missed2", 32'(opMissedCount), 2);
    check_val("ovr_pkt_len", 32'(s_cnt), 4);
    check_val("ovr_eop_pos", eop_mask, 32'h8);
    ipEnable = 0; ipTrigger = 0; ipSampleValid = 0; ipClearStatus = 1;
    tick();
    ipClearStatus = 0;
    tick();
    check_val("clr_ovr", 32'(opOverrun), 0);
    check_val("clr_missed", 32'(opMissedCount), 0);

    // Enable withdrawn during packet 1 of 3.
    clear_obs();
    ipEnable = 1; ipBurstLength = 3; ipSampleValid = 1; ntrig = 0;
    for (int c = 0; c < 20; c++) begin
      ipSampleData = 14'($urandom);
      if (m_capt && m_idx == 1) ipEnable = 0;
      if (m_active && !m_capt && !ipTrigger && ntrig < 2) begin
        ipTrigger = 1; ntrig++;
      end else ipTrigger = 0;
      tick();
    end
    check_val("abort_eop_pos", eop_mask, 32'h88);
    check_val("abort_eob", eob_mask, 0);
    check_val("abort_done", done_mask, 0);
    check_val("abort_busy", 32'(opBusy), 0);
    check_val("abort_index", 32'(opPacketIndex), 1);
    idle_inputs();
    tick();

    // Zero burst length never arms.
    clear_obs();
    ipEnable = 1; ipBurstLength = 0; ipSampleValid = 1;
    for (int c = 0; c < 10; c++) begin
      ipTrigger = c[0];
      tick();
    end
    check_val("len0_busy", 32'(opBusy), 0);
    check_val("len0_valid_count", 32'(s_cnt), 0);
    ipTrigger = 0; ipBurstLength = 2;
    tick();
    check_val("len2_busy", 32'(opBusy), 1);
    idle_inputs();
    repeat (2) tick();

    // Data format at the sign boundary.
    clear_obs();
    ipEnable = 1; ipBurstLength = 1;
    tick();
    ipTrigger = 1; ipSampleValid = 1; ipSampleData = 14'h1234;
    tick();
    ipTrigger = 0; ipSampleData = 14'h2000;
    tick();
    ipSampleData = 14'h1FFF;
    tick();
    ipSampleData = 14'($urandom);
    repeat (3) tick();
`ifdef RX_SEQ_OFFSET_BINARY_EN
    exp0 = 14'h0000; exp1 = 14'h3FFF;
`else
    exp0 = 14'h2000; exp1 = 14'h1FFF;
`endif
    check_val("fmt_count", 32'(s_cnt), 4);
    check_val("fmt_neg_full", 32'(data_log[0]), 32'(exp0));
    check_val("fmt_pos_full", 32'(data_log[1]), 32'(exp1));
    idle_inputs();
    tick();

    // Missed-trigger counter saturation.
    ipEnable = 1; ipBurstLength = 1;
    tick();
    ipTrigger = 1;
    tick();
    for (int c = 0; c < 600; c++) begin
      ipTrigger = ~ipTrigger;
      tick();
    end
    check_val("sat_missed", 32'(opMissedCount), 255);
    check_val("sat_ovr", 32'(opOverrun), 1);
    ipTrigger = 0; ipSampleValid = 1;
    repeat (5) tick();
    ipClearStatus = 1; ipTrigger = 0;
    tick();
    idle_inputs();
    tick();

    // Asynchronous reset mid-packet.
    ipEnable = 1; ipBurstLength = 2;
    tick();
    ipTrigger = 1; ipSampleValid = 1;
    tick();
    ipTrigger = 0;
    repeat (2) tick();
    #3;
    ipnReset = 0;
    #1;
    check_val("arst_valid", 32'(opValid), 0);
    check_val("arst_flags", 32'({opSoP, opEoP, opSoB, opEoB, opBurstDone}), 0);
    check_val("arst_data", 32'(opData), 0);
    check_val("arst_busy", 32'(opBusy), 0);
    check_val("arst_status", 32'({opOverrun, opMissedCount, opPacketIndex}), 0);
    model_reset();
    idle_inputs();
    @(posedge ipClk);
    #1;
    ipnReset = 1;
    clear_obs();
    ipEnable = 1; ipBurstLength = 2;
    tick();
    ipTrigger = 1;
    tick();
    ipTrigger = 0; ipSampleValid = 1;
    repeat (2) tick();
    check_val("post_rst_sop", sop_mask, 32'h1);
    check_val("post_rst_sob", sob_mask, 32'h1);
    idle_inputs();
    tick();

    // Random stimulus.
    for (int c = 0; c < 3000; c++) begin
      ipEnable      = ($urandom_range(0, 9) != 0);
      ipBurstLength = IW'($urandom_range(0, 3));
      ipTrigger     = ($urandom_range(0, 2) == 0);
      ipSampleValid = ($urandom_range(0, 3) != 0);
      ipClearStatus = ($urandom_range(0, 19) == 0);
      ipSampleData  = 14'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/receiver_burst_sequencer.md
# receiver_burst_sequencer

Sequences the receiver ADC sample stream into a burst of fixed-length packets, one packet per pulse trigger, for a run-time-programmable number of pulses. It sits between the ADC sample interface (14-bit data plus a valid strobe) and the downstream packet consumer, such as the debug streamer or the DSP chain. It replaces free-running single-packet capture with burst-level control and status: busy state, packet index, burst-done pulse and overrun detection.

## Interface
Parameters:
- N_SAMPLES, 2500, samples per packet (1..4095)
- INDEX_W, 8, width of burst-length and packet-index fields

Ports:
- ipClk  in  1  single clock for the whole block
- ipnReset  in  1  asynchronous, active-low reset
- ipEnable  in  1  level; arms a burst when high, stops sequencing when low
- ipBurstLength  in  INDEX_W  packets per burst; latched when the block leaves Idle; 0 means never arm
- ipTrigger  in  1  pulse trigger; acts on its rising edge only
- ipClearStatus  in  1  one-cycle pulse; clears opOverrun and opMissedCount
- ipSampleData  in  14  ADC sample, two's complement
- ipSampleValid  in  1  one-cycle sample strobe
- opSoP / opEoP  out  1  first / last sample of a packet, qualified by opValid
- opSoB / opEoB  out  1  first / last sample of a burst, qualified by opValid
- opData  out  14  sample data
- opValid  out  1  output sample strobe
- opPacketIndex  out  INDEX_W  index of the current or next packet within the burst
- opBusy  out  1  high whenever the state is not Idle
- opBurstDone  out  1  one-cycle pulse when a burst completes
- opOverrun  out  1  sticky: a trigger edge arrived while in Sampling
- opMissedCount  out  8  saturating count of triggers that arrived during Sampling

## Operation
- Trigger edge: a register holds the previous ipTrigger; edge = ipTrigger & ~prev.
- States are Idle, Armed and Sampling.
- Idle → Armed: when ipEnable=1 and ipBurstLength≠0. The block latches the burst length (L) and clears the index to 0.
- Armed → Sampling: on a trigger edge. The sample counter n is cleared to 0.
- Armed → Idle: when ipEnable=0.
- Sampling:
  - Each ipSampleValid forwards one sample and increments n.
  - opSoP = (n==0); opEoP = (n==N_SAMPLES-1).
  - opSoB = opSoP & (index==0); opEoB = opEoP & (index==L-1).
- End of packet (the sample with n==N_SAMPLES-1 is accepted):
  - If index==L-1: go to Idle and pulse opBurstDone.
  - Else, if ipEnable=0: go to Idle without opBurstDone (burst aborted).
  - Else: increment the index and go to Armed.
- ipEnable falling during Sampling: the current packet always completes, so packets are never truncated.
- Samples are dropped outside Sampling. Valid strobes arriving in Armed or Idle produce no output.
- A trigger edge in Sampling does not restart the packet. It sets opOverrun and increments opMissedCount, which saturates at 255.
- A trigger edge in Idle is ignored.
- ipClearStatus and an overrun in the same cycle: the clear wins, then the new event is applied, so opOverrun=1 and opMissedCount=1.
- ipBurstLength changes take effect only at the next Idle→Armed transition.

## Timing
- Reset values:
  - All outputs 0; opPacketIndex 0.
  - State Idle, n=0, previous-trigger register 0.
- Reset mid-burst aborts immediately with no opEoP or opBurstDone.
- Sample latency: ipSampleValid at cycle t → opValid at t+1, together with registered data and flags.
- Trigger latency: edge at cycle t (in Armed) → state is Sampling at t+1. The first sample accepted is any ipSampleValid at t+1 or later. A valid strobe coinciding with the edge cycle is dropped.
- End of packet: the last sample accepted at t gives opEoP at t+1. The state is Armed or Idle at t+1. opBurstDone pulses at t+1, coincident with opEoB.
- Re-arm: a trigger edge at t+1 is accepted for the next packet.
- Back-to-back valid strobes are supported every cycle.
- n is wide enough for N_SAMPLES-1. It never wraps because it clears on every Sampling entry.

## Configuration
- Macro RX_SEQ_OFFSET_BINARY_EN.
- Defined: opData = {~ipSampleData[13], ipSampleData[12:0]} (offset binary).
- Undefined: opData = ipSampleData unchanged (two's complement).
- Flags and timing are identical in both builds.

## Test plan
- Use N_SAMPLES=4, L=3, enable, 3 triggers with continuous valid strobes. Expect 12 opValid, SoP at samples 0/4/8 and EoP at 3/7/11. Expect opSoB only on sample 0, opEoB and opBurstDone only on sample 11, and opBusy falling after sample 11.
- Send a trigger edge mid-packet twice, then pulse ipClearStatus. Expect opOverrun=1 and opMissedCount=2 with the packet length unaffected (4 samples). After the clear, both read 0.
- Drop ipEnable during packet 1 of 3. Expect packet 1 to complete with EoP. Then expect Idle, opBurstDone=0, opEoB never asserted, and opPacketIndex=1 held.
- Set ipBurstLength=0 with enable high and triggers present. Expect opBusy=0 and no opValid. Setting length 2 then arms, with opBusy=1.
- Build with RX_SEQ_OFFSET_BINARY_EN and input 14'h2000 then 14'h1FFF. Expect opData 14'h0000 and 14'h3FFF; without the macro, expect the values unchanged.
- Assert ipnReset low mid-packet. Expect all outputs to go to 0 asynchronously. After release, the first trigger starts packet index 0 with SoP and SoB.
